// File: rtl/sandpile_drop_scheduler.sv
// Drop scheduler for the sandpile array: arbitrates two requesters plus an
// auto-drop generator into a small FIFO and issues at most one drop per frame.
module sandpile_drop_scheduler #(
    parameter int COORD_W    = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            new_frame_i,
    input  logic [COORD_W-1:0]              resolution_i,
    input  logic                            req_a_i,
    input  logic [COORD_W-1:0]              x_a_i,
    input  logic [COORD_W-1:0]              y_a_i,
    output logic                            ack_a_o,
    input  logic                            req_b_i,
    input  logic [COORD_W-1:0]              x_b_i,
    input  logic [COORD_W-1:0]              y_b_i,
    output logic                            ack_b_o,
    input  logic                            auto_en_i,
    input  logic [PERIOD_W-1:0]             auto_period_i,
    output logic                            drop_o,
    output logic [COORD_W-1:0]              drop_x_o,
    output logic [COORD_W-1:0]              drop_y_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
    output logic                            overflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t               r_state, w_state_next;
    logic [COORD_W-1:0]   r_mem_x [FIFO_DEPTH];
    logic [COORD_W-1:0]   r_mem_y [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_rr_b;
    logic [PERIOD_W-1:0]  r_auto_cnt;
    logic                 r_pending;

    logic [COORD_W-1:0]   w_res;
    logic [PERIOD_W-1:0]  w_period;
    logic [PERIOD_W:0]    w_cnt_inc;
    logic                 w_full, w_grant_a, w_grant_b, w_grant_auto, w_push, w_pop;
    logic                 w_period_done;
    logic [COORD_W-1:0]   w_push_x, w_push_y;

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] c,
                                                 input logic [COORD_W-1:0] r);
        return (c >= r) ? r - 1'b1 : c;
    endfunction

    assign w_res    = (resolution_i == '0) ? COORD_W'(1) : resolution_i;
    assign w_period = (auto_period_i == '0) ? PERIOD_W'(1) : auto_period_i;
    assign w_full   = (r_count == FULL_CNT);

    // Round-robin only matters when both requesters contend; auto is last resort.
    assign w_grant_a    = req_a_i && !w_full && (!req_b_i || !r_rr_b);
    assign w_grant_b    = req_b_i && !w_full && (!req_a_i || r_rr_b);
    assign w_grant_auto = auto_en_i && r_pending && !req_a_i && !req_b_i && !w_full;
    assign w_push       = w_grant_a || w_grant_b || w_grant_auto;
    assign w_pop        = (r_state == S_ISSUE);
    assign ack_a_o      = w_grant_a;
    assign ack_b_o      = w_grant_b;

    always_comb begin
        w_push_x = w_res >> 1;
        w_push_y = w_res >> 1;
        if (w_grant_a) begin
            w_push_x = clamp(x_a_i, w_res);
            w_push_y = clamp(y_a_i, w_res);
        end else if (w_grant_b) begin
            w_push_x = clamp(x_b_i, w_res);
            w_push_y = clamp(y_b_i, w_res);
        end
    end

    assign w_cnt_inc     = {1'b0, r_auto_cnt} + (PERIOD_W+1)'(1);
    assign w_period_done = auto_en_i && new_frame_i && (w_cnt_inc >= {1'b0, w_period});
    assign overflow_o    = w_period_done && w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= w_push_x;
            r_mem_y[r_wr_ptr] <= w_push_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_b   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_grant_a)      r_rr_b <= 1'b1;
            else if (w_grant_b) r_rr_b <= 1'b0;
        end
    end

    // A newly completed period takes precedence over consuming the old request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto_cnt <= '0;
            r_pending  <= 1'b0;
        end else if (!auto_en_i) begin
            r_auto_cnt <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (w_grant_auto) r_pending <= 1'b0;
            if (new_frame_i) begin
                if (w_period_done) begin
                    r_auto_cnt <= '0;
                    if (!w_full) r_pending <= 1'b1;
                end else begin
                    r_auto_cnt <= w_cnt_inc[PERIOD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (new_frame_i && r_count != '0) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (!new_frame_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        drop_o   = 1'b0;
        drop_x_o = '0;
        drop_y_o = '0;
        if (r_state == S_ISSUE) begin
            drop_o   = 1'b1;
            drop_x_o = r_mem_x[r_rd_ptr];
            drop_y_o = r_mem_y[r_rd_ptr];
        end
    end

    assign fifo_count_o = r_count;
endmodule

// File: tb/tb_sandpile_drop_scheduler.sv
// Randomized and directed checks of sandpile_drop_scheduler against a
// queue-based reference model of the drop scheduling rules.
module tb_sandpile_drop_scheduler;
    logic       clk = 0;
    logic       rst;
    logic       new_frame;
    logic [8:0] res;
    logic       req_a, req_b;
    logic [8:0] xa, ya, xb, yb;
    logic       auto_en;
    logic [7:0] period;
    logic       ack_a, ack_b, drop, ov;
    logic [8:0] dx, dy;
    logic [2:0] cnt;

    int errors = 0;
    int checks = 0;

    sandpile_drop_scheduler #(.COORD_W(9), .FIFO_DEPTH(4), .PERIOD_W(8)) dut (
        .clk(clk), .rst(rst), .new_frame_i(new_frame), .resolution_i(res),
        .req_a_i(req_a), .x_a_i(xa), .y_a_i(ya), .ack_a_o(ack_a),
        .req_b_i(req_b), .x_b_i(xb), .y_b_i(yb), .ack_b_o(ack_b),
        .auto_en_i(auto_en), .auto_period_i(period),
        .drop_o(drop), .drop_x_o(dx), .drop_y_o(dy),
        .fifo_count_o(cnt), .overflow_o(ov)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [8:0] q_x[$];
    logic [8:0] q_y[$];
    bit m_turn_b, m_pend, m_drop;
    int m_cnt;
    bit g_ea, g_eb;

    // snapshots of the DUT outputs at the last checked cycle
    bit s_ack_a, s_ack_b, s_drop, s_ov;
    int s_x, s_y, s_count;
    int auto_drops, ov_total;
    int dlog_x[$];
    int dlog_y[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] clampv(input logic [8:0] c, input int r);
        return (int'(c) >= r) ? 9'(r - 1) : c;
    endfunction

    task automatic model_reset();
        q_x.delete(); q_y.delete();
        m_turn_b = 0; m_pend = 0; m_drop = 0; m_cnt = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        int R, P, pre;
        bit full, ea, eb, eauto, done, eov;
        logic [8:0] ex, ey;
        @(negedge clk);
        R = (res == 0) ? 1 : int'(res);
        P = (period == 0) ? 1 : int'(period);
        full  = (q_x.size() == 4);
        ea    = req_a && !full && (!req_b || !m_turn_b);
        eb    = req_b && !full && (!req_a || m_turn_b);
        eauto = auto_en && m_pend && !req_a && !req_b && !full;
        done  = auto_en && new_frame && (m_cnt + 1 >= P);
        eov   = done && full;
        ex = m_drop ? q_x[0] : 9'd0;
        ey = m_drop ? q_y[0] : 9'd0;
        chk("ack_a", int'(ack_a), int'(ea));
        chk("ack_b", int'(ack_b), int'(eb));
        chk("drop", int'(drop), int'(m_drop));
        chk("drop_x", int'(dx), int'(ex));
        chk("drop_y", int'(dy), int'(ey));
        chk("fifo_count", int'(cnt), q_x.size());
        chk("overflow", int'(ov), int'(eov));
        s_ack_a = ack_a; s_ack_b = ack_b; s_drop = drop; s_ov = ov;
        s_x = int'(dx); s_y = int'(dy); s_count = int'(cnt);
        if (ov) ov_total++;
        if (drop) begin
            $display("drop (%0d,%0d) count=%0d t=%0t", dx, dy, cnt, $time);
            dlog_x.push_back(int'(dx)); dlog_y.push_back(int'(dy));
            if (dx == 16 && dy == 16) auto_drops++;
        end
        g_ea = ea; g_eb = eb;
        @(posedge clk);
        pre = q_x.size();
        if (m_drop) begin void'(q_x.pop_front()); void'(q_y.pop_front()); end
        m_drop = new_frame && (pre > 0);
        if (ea) begin q_x.push_back(clampv(xa, R)); q_y.push_back(clampv(ya, R)); m_turn_b = 1; end
        if (eb) begin q_x.push_back(clampv(xb, R)); q_y.push_back(clampv(yb, R)); m_turn_b = 0; end
        if (eauto) begin q_x.push_back(9'(R / 2)); q_y.push_back(9'(R / 2)); end
        if (!auto_en) begin
            m_cnt = 0; m_pend = 0;
        end else begin
            if (eauto) m_pend = 0;
            if (new_frame) begin
                if (done) begin m_cnt = 0; if (!full) m_pend = 1; end
                else m_cnt++;
            end
        end
        #1;
    endtask

    task automatic frame_gap();
        new_frame = 1; step();
        new_frame = 0; step(); step(); step();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q_x.size() > 0; i++) frame_gap();
        chk("drained", q_x.size(), 0);
    endtask

    task automatic push_a(input int x, input int y);
        req_a = 1; xa = 9'(x); ya = 9'(y); step();
        req_a = 0; step();
    endtask

    int gap;

    initial begin
        rst = 1; new_frame = 0; res = 9'd32; req_a = 0; req_b = 0;
        xa = 0; ya = 0; xb = 0; yb = 0; auto_en = 0; period = 8'd1;
        model_reset();
        #22;
        chk("rst_drop", int'(drop), 0);
        chk("rst_count", int'(cnt), 0);
        chk("rst_ack_a", int'(ack_a), 0);
        chk("rst_ack_b", int'(ack_b), 0);
        chk("rst_ov", int'(ov), 0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // A and B contending: ABAB then both stalled on full
        req_a = 1; xa = 1; ya = 1; req_b = 1; xb = 2; yb = 2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_ack_a", int'(s_ack_a), (i % 2 == 0) ? 1 : 0);
            chk("rr_ack_b", int'(s_ack_b), (i % 2 == 1) ? 1 : 0);
        end
        step();
        chk("full_ack_a", int'(s_ack_a), 0);
        chk("full_ack_b", int'(s_ack_b), 0);
        chk("full_count", s_count, 4);
        new_frame = 1; step(); new_frame = 0; step();
        chk("ab_drop_x", s_x, 1);
        step();
        chk("turn_a_ack", int'(s_ack_a), 1);
        chk("turn_b_blocked", int'(s_ack_b), 0);
        req_a = 0; req_b = 0;
        step();
        drain();

        // Single request
        res = 9'd32;
        req_a = 1; xa = 5; ya = 7; step();
        chk("single_ack", int'(s_ack_a), 1);
        req_a = 0; step();
        chk("single_count", s_count, 1);
        new_frame = 1; step(); new_frame = 0; step();
        chk("single_drop", int'(s_drop), 1);
        chk("single_x", s_x, 5);
        chk("single_y", s_y, 7);
        step();
        chk("single_drop_end", int'(s_drop), 0);
        chk("single_empty", s_count, 0);

        // Clamping
        res = 9'd16; push_a(20, 3);
        new_frame = 1; step(); new_frame = 0; step();
        chk("clamp16_x", s_x, 15); chk("clamp16_y", s_y, 3);
        step();
        res = 9'd0; push_a(9, 9);
        new_frame = 1; step(); new_frame = 0; step();
        chk("clamp0_x", s_x, 0); chk("clamp0_y", s_y, 0);
        step();

        // Auto generator, period 3
        res = 9'd32; auto_en = 1; period = 8'd3; auto_drops = 0;
        for (int f = 0; f < 9; f++) frame_gap();
        chk("auto_drops", auto_drops, 2);
        chk("auto_left", int'(cnt), 1);
        auto_en = 0; step();
        drain();

        // Overflow with a full queue
        for (int k = 0; k < 4; k++) push_a(10 + k, 20 + k);
        auto_en = 1; period = 8'd0; step();
        ov_total = 0; dlog_x.delete(); dlog_y.delete();
        new_frame = 1; step();
        chk("ov_pulse", int'(s_ov), 1);
        chk("ov_count", s_count, 4);
        new_frame = 0; step();
        auto_en = 0; step(); step();
        frame_gap(); frame_gap();
        chk("ov_total", ov_total, 1);
        chk("fifo_order_n", dlog_x.size(), 3);
        if (dlog_x.size() == 3) begin
            chk("fifo_order_0", dlog_x[0] * 100 + dlog_y[0], 1020);
            chk("fifo_order_1", dlog_x[1] * 100 + dlog_y[1], 1121);
            chk("fifo_order_2", dlog_x[2] * 100 + dlog_y[2], 1222);
        end
        chk("ov_left", int'(cnt), 1);

        // Reset during an issue cycle
        new_frame = 1; step(); new_frame = 0;
        rst = 1; #1;
        chk("rst_mid_drop", int'(drop), 0);
        chk("rst_mid_count", int'(cnt), 0);
        model_reset();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Randomized traffic
        gap = 3;
        for (int c = 0; c < 4000; c++) begin
            if (g_ea) req_a = 0;
            if (g_eb) req_b = 0;
            if (!req_a && ($urandom % 3 == 0)) begin
                req_a = 1; xa = 9'($urandom_range(0, 40)); ya = 9'($urandom_range(0, 40));
            end
            if (!req_b && ($urandom % 3 == 0)) begin
                req_b = 1; xb = 9'($urandom_range(0, 40)); yb = 9'($urandom_range(0, 40));
            end
            if ($urandom % 50 == 0) begin
                case ($urandom % 5)
                    0: res = 9'd0;
                    1: res = 9'd1;
                    2: res = 9'd16;
                    3: res = 9'd37;
                    default: res = 9'd32;
                endcase
            end
            if ($urandom % 150 == 0) auto_en = ~auto_en;
            if ($urandom % 60 == 0) period = 8'($urandom_range(0, 3));
            gap--;
            if (gap == 0) begin
                new_frame = 1; gap = $urandom_range(3, 7);
            end else begin
                new_frame = 0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
